// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
package pc_pkg;

   typedef enum logic [1:0] {
      ARRANQUE,
      FETCH,
      ESPERA,
      PARADO
   } estado_t;

   localparam int          ANCHO_PC      = 64;
   localparam int          INCREMENTO_PC = 4;
   localparam logic [63:0] RESET_ADDR_PC = 64'h0;

endpackage

// File: rtl/contador_pc_if.sv
// Instruction-memory request channel: fetch address with a valid/ready handshake.
interface contador_pc_if import pc_pkg::*; #(
   parameter int ANCHO = ANCHO_PC
);
   logic [ANCHO-1:0] bus_direccion_im;
   logic             im_req;
   logic             im_ready;

   modport master (output bus_direccion_im, output im_req, input im_ready);
   modport slave  (input bus_direccion_im, input im_req, output im_ready);
endinterface

// File: rtl/suma1.sv
// Plain unsigned adder, result taken modulo 2^ANCHO.
module suma1 #(
   parameter int ANCHO = 64
) (
   input  logic [ANCHO-1:0] a,
   input  logic [ANCHO-1:0] b,
   output logic [ANCHO-1:0] suma
);
   assign suma = a + b;
endmodule

// File: rtl/contador_pc.sv
// Program counter and fetch-address sequencer: sequential stepping, branch
// redirects (buffered while a request is outstanding), stall, sticky halt.
module contador_pc import pc_pkg::*; #(
   parameter int               ANCHO      = ANCHO_PC,
   parameter logic [ANCHO-1:0] RESET_ADDR = ANCHO'(RESET_ADDR_PC),
   parameter int               INCREMENTO = INCREMENTO_PC
) (
   input  logic             clk,
   input  logic             reset,
   contador_pc_if.master    im,
   input  logic             branch_taken,
   input  logic [ANCHO-1:0] result_suma,
   input  logic             stall,
   input  logic             halt,
   output logic [ANCHO-1:0] pc_mas4,
   output logic             halted,
   output logic             err_alineacion,
   output logic [31:0]      cnt_fetch
);

   localparam logic [ANCHO-1:0] PASO = ANCHO'(INCREMENTO);

   estado_t          state_reg, state_next;
   logic [ANCHO-1:0] pc_reg, pc_next;
   logic             pend_valid_reg, pend_valid_next;
   logic [ANCHO-1:0] pend_target_reg, pend_target_next;
   logic             halt_pend_reg, halt_pend_next;
   logic             err_reg, err_next;
   logic [31:0]      cnt_reg, cnt_next;
   logic [ANCHO-1:0] target_al;
   logic             misalineado;

   suma1 #(.ANCHO(ANCHO)) u_suma (
      .a    (pc_reg),
      .b    (PASO),
      .suma (pc_mas4)
   );

   assign target_al   = {result_suma[ANCHO-1:2], 2'b00};
   assign misalineado = (result_suma[1:0] != 2'b00);

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      pend_valid_next  = pend_valid_reg;
      pend_target_next = pend_target_reg;
      halt_pend_next   = halt_pend_reg;
      err_next         = err_reg;
      cnt_next         = cnt_reg;

      if (state_reg != PARADO && branch_taken && misalineado)
         err_next = 1'b1;

      case (state_reg)
         ARRANQUE, ESPERA: begin
            if (branch_taken) begin
               pc_next         = target_al;
               pend_valid_next = 1'b0;
            end
            if (halt)       state_next = PARADO;
            else if (stall) state_next = ESPERA;
            else            state_next = FETCH;
         end
         FETCH: begin
            if (im.im_ready) begin
               cnt_next        = cnt_reg + 32'd1;
               pend_valid_next = 1'b0;
               halt_pend_next  = 1'b0;
               if (branch_taken)        pc_next = target_al;
               else if (pend_valid_reg) pc_next = pend_target_reg;
               else                     pc_next = pc_mas4;
               if (halt || halt_pend_reg) state_next = PARADO;
               else if (stall)            state_next = ESPERA;
               else                       state_next = FETCH;
            end else begin
               // Address stays frozen; remember redirects and halts for acceptance.
               if (branch_taken) begin
                  pend_valid_next  = 1'b1;
                  pend_target_next = target_al;
               end
               halt_pend_next = halt_pend_reg | halt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ARRANQUE;
         pc_reg          <= RESET_ADDR;
         pend_valid_reg  <= 1'b0;
         pend_target_reg <= '0;
         halt_pend_reg   <= 1'b0;
         err_reg         <= 1'b0;
         cnt_reg         <= '0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         pend_valid_reg  <= pend_valid_next;
         pend_target_reg <= pend_target_next;
         halt_pend_reg   <= halt_pend_next;
         err_reg         <= err_next;
         cnt_reg         <= cnt_next;
      end
   end

   assign im.bus_direccion_im = pc_reg;
   assign im.im_req           = (state_reg == FETCH);
   assign halted              = (state_reg == PARADO);
   assign err_alineacion      = err_reg;
   assign cnt_fetch           = cnt_reg;

endmodule

// File: tb/tb_contador_pc.sv
// Bench for contador_pc: directed vector table, a boot-halt sequence and
// randomized traffic compared against a behavioural reference model.
module tb_contador_pc;

   logic        clk = 1'b0;
   logic        rst;
   logic        branch_taken;
   logic [63:0] result_suma;
   logic        stall;
   logic        halt;
   logic [63:0] pc_mas4;
   logic        halted;
   logic        err_alineacion;
   logic [31:0] cnt_fetch;

   int tests = 0;
   int fails = 0;

   contador_pc_if bus ();

   contador_pc dut (
      .clk            (clk),
      .reset          (rst),
      .im             (bus),
      .branch_taken   (branch_taken),
      .result_suma    (result_suma),
      .stall          (stall),
      .halt           (halt),
      .pc_mas4        (pc_mas4),
      .halted         (halted),
      .err_alineacion (err_alineacion),
      .cnt_fetch      (cnt_fetch)
   );

   always #5 clk = ~clk;

   // Reference model: what the fetch unit is doing, in plain terms.
   typedef enum {M_BOOT, M_RUN, M_HOLD, M_STOP} modo_t;
   modo_t       m_mode;
   logic [63:0] m_pc, m_ptgt;
   logic        m_pend, m_hpend, m_err;
   logic [31:0] m_cnt;

   task automatic model_step(input logic r, input logic rdy, input logic br,
                             input logic [63:0] tgt, input logic st, input logic ht);
      logic [63:0] al;
      al = tgt & ~64'd3;
      if (r) begin
         m_mode = M_BOOT; m_pc = 64'd0; m_pend = 0; m_ptgt = 0;
         m_hpend = 0; m_err = 0; m_cnt = 0;
         return;
      end
      if (m_mode == M_STOP) return;
      if (br && tgt[1:0] != 2'b00) m_err = 1;
      if (m_mode == M_RUN) begin
         if (rdy) begin
            m_cnt = m_cnt + 1;
            m_pc = br ? al : (m_pend ? m_ptgt : m_pc + 64'd4);
            m_pend = 0;
            m_mode = (ht || m_hpend) ? M_STOP : (st ? M_HOLD : M_RUN);
            m_hpend = 0;
         end else begin
            if (br) begin m_pend = 1; m_ptgt = al; end
            if (ht) m_hpend = 1;
         end
      end else begin
         if (br) begin m_pc = al; m_pend = 0; end
         m_mode = ht ? M_STOP : (st ? M_HOLD : M_RUN);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rdy, input logic br,
                        input logic [63:0] tgt, input logic st, input logic ht);
      rst = r; bus.im_ready = rdy; branch_taken = br; result_suma = tgt;
      stall = st; halt = ht;
      model_step(r, rdy, br, tgt, st, ht);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".addr"},   bus.bus_direccion_im, m_pc);
      chk({tag, ".req"},    64'(bus.im_req),      64'(m_mode == M_RUN));
      chk({tag, ".halted"}, 64'(halted),          64'(m_mode == M_STOP));
      chk({tag, ".err"},    64'(err_alineacion),  64'(m_err));
      chk({tag, ".cnt"},    64'(cnt_fetch),       64'(m_cnt));
      chk({tag, ".pc4"},    pc_mas4,              m_pc + 64'd4);
   endtask

   typedef struct {
      logic        r, rdy, br;
      logic [63:0] tgt;
      logic        st, ht;
      logic [63:0] e_addr;
      logic        e_req, e_halt, e_err;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t v(input logic r, input logic rdy, input logic br,
                              input logic [63:0] tgt, input logic st, input logic ht,
                              input logic [63:0] ea, input logic eq, input logic eh,
                              input logic ee, input logic [31:0] ec);
      vec_t x;
      x.r = r; x.rdy = rdy; x.br = br; x.tgt = tgt; x.st = st; x.ht = ht;
      x.e_addr = ea; x.e_req = eq; x.e_halt = eh; x.e_err = ee; x.e_cnt = ec;
      return x;
   endfunction

   vec_t tbl [32];

   initial begin
      //               r  rdy br tgt                    st ht | addr                   req hlt err cnt
      tbl[0]  = v(1, 0, 0, 64'h0,                  0, 0, 64'h0,                  0, 0, 0, 0);
      tbl[1]  = v(1, 1, 0, 64'h0,                  0, 0, 64'h0,                  0, 0, 0, 0);
      tbl[2]  = v(0, 1, 0, 64'h0,                  0, 0, 64'h0,                  1, 0, 0, 0);
      tbl[3]  = v(0, 1, 0, 64'h0,                  0, 0, 64'h4,                  1, 0, 0, 1);
      tbl[4]  = v(0, 1, 0, 64'h0,                  0, 0, 64'h8,                  1, 0, 0, 2);
      tbl[5]  = v(0, 1, 0, 64'h0,                  0, 0, 64'hC,                  1, 0, 0, 3);
      tbl[6]  = v(0, 1, 0, 64'h0,                  0, 0, 64'h10,                 1, 0, 0, 4);
      tbl[7]  = v(0, 0, 1, 64'h400,                0, 0, 64'h10,                 1, 0, 0, 4);
      tbl[8]  = v(0, 0, 0, 64'h0,                  0, 0, 64'h10,                 1, 0, 0, 4);
      tbl[9]  = v(0, 1, 0, 64'h0,                  0, 0, 64'h400,                1, 0, 0, 5);
      tbl[10] = v(0, 1, 0, 64'h0,                  0, 0, 64'h404,                1, 0, 0, 6);
      tbl[11] = v(0, 0, 1, 64'h400,                0, 0, 64'h404,                1, 0, 0, 6);
      tbl[12] = v(0, 1, 1, 64'h800,                0, 0, 64'h800,                1, 0, 0, 7);
      tbl[13] = v(0, 1, 0, 64'h0,                  0, 0, 64'h804,                1, 0, 0, 8);
      tbl[14] = v(0, 1, 1, 64'h20,                 0, 0, 64'h20,                 1, 0, 0, 9);
      tbl[15] = v(0, 1, 0, 64'h0,                  1, 0, 64'h24,                 0, 0, 0, 10);
      tbl[16] = v(0, 1, 0, 64'h0,                  1, 0, 64'h24,                 0, 0, 0, 10);
      tbl[17] = v(0, 0, 1, 64'h100,                1, 0, 64'h100,                0, 0, 0, 10);
      tbl[18] = v(0, 0, 0, 64'h0,                  0, 0, 64'h100,                1, 0, 0, 10);
      tbl[19] = v(0, 1, 0, 64'h0,                  0, 0, 64'h104,                1, 0, 0, 11);
      tbl[20] = v(0, 1, 1, 64'h103,                0, 0, 64'h100,                1, 0, 1, 12);
      tbl[21] = v(0, 1, 0, 64'h0,                  0, 0, 64'h104,                1, 0, 1, 13);
      tbl[22] = v(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 1, 14);
      tbl[23] = v(0, 1, 0, 64'h0,                  0, 0, 64'h0,                  1, 0, 1, 15);
      tbl[24] = v(0, 0, 0, 64'h0,                  0, 1, 64'h0,                  1, 0, 1, 15);
      tbl[25] = v(0, 1, 0, 64'h0,                  0, 1, 64'h4,                  0, 1, 1, 16);
      tbl[26] = v(0, 1, 0, 64'h0,                  0, 0, 64'h4,                  0, 1, 1, 16);
      tbl[27] = v(0, 1, 1, 64'h200,                0, 0, 64'h4,                  0, 1, 1, 16);
      tbl[28] = v(1, 1, 0, 64'h0,                  0, 0, 64'h0,                  0, 0, 0, 0);
      tbl[29] = v(0, 0, 0, 64'h0,                  0, 0, 64'h0,                  1, 0, 0, 0);
      tbl[30] = v(1, 1, 0, 64'h0,                  0, 0, 64'h0,                  0, 0, 0, 0);
      tbl[31] = v(0, 1, 0, 64'h0,                  0, 0, 64'h0,                  1, 0, 0, 0);

      rst = 1; bus.im_ready = 0; branch_taken = 0; result_suma = 0; stall = 0; halt = 0;

      for (int i = 0; i < 32; i++) begin
         drive(tbl[i].r, tbl[i].rdy, tbl[i].br, tbl[i].tgt, tbl[i].st, tbl[i].ht);
         $display("[TB] vec %0d addr=%h req=%0b halted=%0b err=%0b cnt=%0d",
                  i, bus.bus_direccion_im, bus.im_req, halted, err_alineacion, cnt_fetch);
         chk($sformatf("vec%0d.addr", i),   bus.bus_direccion_im, tbl[i].e_addr);
         chk($sformatf("vec%0d.req", i),    64'(bus.im_req),      64'(tbl[i].e_req));
         chk($sformatf("vec%0d.halted", i), 64'(halted),          64'(tbl[i].e_halt));
         chk($sformatf("vec%0d.err", i),    64'(err_alineacion),  64'(tbl[i].e_err));
         chk($sformatf("vec%0d.cnt", i),    64'(cnt_fetch),       64'(tbl[i].e_cnt));
         chk($sformatf("vec%0d.pc4", i),    pc_mas4,              tbl[i].e_addr + 64'd4);
      end

      // Halt sampled in the boot cycle: never requests, halted on the next edge.
      drive(1, 1, 0, 64'h0, 0, 0);
      chk_model("boot_rst");
      drive(0, 1, 1, 64'h3C, 0, 1);
      $display("[TB] boot-halt addr=%h req=%0b halted=%0b", bus.bus_direccion_im, bus.im_req, halted);
      chk_model("boot_halt");
      chk("boot_halt.addr_fixed", bus.bus_direccion_im, 64'h3C);
      drive(0, 1, 0, 64'h0, 0, 0);
      chk_model("boot_halt_hold");

      // Randomized traffic against the reference model.
      drive(1, 0, 0, 64'h0, 0, 0);
      for (int c = 0; c < 400; c++) begin
         logic        r, rdy, br, st, ht;
         logic [63:0] tgt;
         r   = ($urandom_range(0, 149) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         br  = ($urandom_range(0, 4) == 0);
         st  = ($urandom_range(0, 5) == 0);
         ht  = ($urandom_range(0, 79) == 0);
         tgt = {$urandom(), $urandom()};
         if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         drive(r, rdy, br, tgt, st, ht);
         $display("[TB] rnd %0d r=%0b rdy=%0b br=%0b st=%0b ht=%0b addr=%h req=%0b cnt=%0d",
                  c, r, rdy, br, st, ht, bus.bus_direccion_im, bus.im_req, cnt_fetch);
         chk_model($sformatf("rnd%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/contador_pc.md
# contador_pc

- Program-counter and fetch-address sequencer for the 64-bit core.
- Holds the PC and drives `bus_direccion_im` to instruction memory through a valid/ready request.
- Takes the branch target `result_suma` from the branch-target adder on a taken branch.
- Handles stalls, sticky halt and misaligned branch targets; redirects that arrive mid-request are buffered.

## Interface

Parameters:
- `ANCHO`, 64: address/PC width.
- `RESET_ADDR`, 64'h0: PC value after reset.
- `INCREMENTO`, 4: sequential step in bytes.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bus_direccion_im`  out  ANCHO  fetch address; equals the PC register.
- `im_req`  out  1  fetch request valid.
- `im_ready`  in  1  instruction memory accepts request; acceptance = `im_req & im_ready`.
- `branch_taken`  in  1  single-cycle pulse: redirect to `result_suma`.
- `result_suma`  in  ANCHO  branch target, valid only with `branch_taken`.
- `stall`  in  1  pipeline stall request; level-sensitive.
- `halt`  in  1  stop fetching; sticky until reset.
- `pc_mas4`  out  ANCHO  combinational PC + INCREMENTO, modulo 2^ANCHO.
- `halted`  out  1  high in PARADO.
- `err_alineacion`  out  1  sticky; set when a taken target has bits [1:0] ≠ 0.
- `cnt_fetch`  out  32  count of accepted requests; wraps at 2^32.

## Operation

States:
- **ARRANQUE:** `im_req`=0. Next state: PARADO if `halt`, else ESPERA if `stall`, else FETCH.
- **FETCH:** `im_req`=1. The address is frozen until acceptance.
- **ESPERA:** `im_req`=0. Returns to FETCH when `stall`=0.
- **PARADO:** `im_req`=0, `halted`=1. Only `reset` exits this state.

Reset values: PC=RESET_ADDR, state=ARRANQUE, `im_req`=0, `halted`=0, `err_alineacion`=0, `cnt_fetch`=0, pending-redirect register cleared.

Redirect buffer (`pend_valid`, `pend_target`):
- In FETCH, `branch_taken` without acceptance: latch target into `pend_target`, set `pend_valid`.
- A newer branch overwrites an older pending one.

Next PC on acceptance, in priority order:
1. `result_suma`, if `branch_taken` is high in the same cycle (pending buffer discarded).
2. Else `pend_target`, if `pend_valid`.
3. Else `pc_mas4`.
- `pend_valid` clears on acceptance.
- `cnt_fetch` increments on every acceptance.

Next state after acceptance:
- PARADO if `halt`.
- Else ESPERA if `stall`.
- Else stays in FETCH.

ESPERA and ARRANQUE behaviour:
- `branch_taken` loads the PC directly from the target and clears the pending buffer.
- `halt` → PARADO.

Boundary rules:
- `halt` and `stall` never drop `im_req` before acceptance.
- Target alignment: bits [1:0] are forced to 0 before loading; `err_alineacion` is set in the same cycle.
- PC wrap-around: PC = 2^ANCHO−4 steps to 0, no flag.
- `reset` mid-request: next cycle `im_req`=0 and PC=RESET_ADDR regardless of `im_ready`.

## Timing

- Back-to-back fetch: with `im_ready` held high, one acceptance per cycle, and `bus_direccion_im` advances every cycle.
- Latency: acceptance at edge N → new address visible on `bus_direccion_im` after edge N.
- First request: `im_req` rises one cycle after `reset` deasserts (ARRANQUE lasts exactly one cycle).
- `halted` rises the cycle after the halting acceptance or the ESPERA/ARRANQUE cycle where `halt` is sampled.
- `pc_mas4` is the only combinational output; all other outputs are registered.

## Structure

- Shared package `pc_pkg`:
  - state enum {ARRANQUE, FETCH, ESPERA, PARADO}.
  - constants `ANCHO_PC`=64, `INCREMENTO_PC`=4, `RESET_ADDR_PC`.
- One sub-module: the existing `suma1` adder, instantiated for `pc_mas4` with its second operand tied to INCREMENTO.
- Everything else is flat: PC register, redirect buffer, FSM, counter.

## Test plan

- **Reset and stream:** release reset with `im_ready`=1 → `im_req` rises 1 cycle later; addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles; `cnt_fetch`=4.
- **Backpressure plus buffered branch:**
  - Setup: `im_ready`=0 with PC=0x10; pulse `branch_taken` with `result_suma`=0x400.
  - Expected while waiting: address holds 0x10.
  - Expected on acceptance: next address 0x400, then 0x404.
- **Same-cycle override:**
  - Setup: pending target 0x400; at the acceptance cycle pulse `branch_taken` with 0x800.
  - Expected: next address 0x800 and the pending target is discarded.
- **Stall:**
  - Setup: `stall`=1 at acceptance of 0x20.
  - Expected during stall: ESPERA, `im_req`=0.
  - Branch to 0x100 while in ESPERA → on release, first address 0x100.
- **Misalignment and wrap:**
  - Branch to 0x103 → address 0x100, `err_alineacion`=1 and stays set.
  - From PC=0xFFFF_FFFF_FFFF_FFFC, accept → address 0x0.
- **Halt and reset mid-request:**
  - `halt` during a pending request → request still completes, then `halted`=1, `im_req`=0 indefinitely.
  - Assert `reset` → PC=0, all flags cleared.
